// File: rtl/bg_pattern_checker.sv
// bg_pattern_checker: encodes MBIST read data back to its background pattern
// code, compares it with the expected code and keeps per-run pass/fail
// statistics plus a snapshot of the first failing read.
// Optional macro MBIST_CHK_BITMAP_EN enables the sticky per-bit fail map;
// without it fail_bitmap is tied to zero.
module bg_pattern_checker #(
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              end_run,
  input  logic              rd_valid,
  input  logic [7:0]        rd_data,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [2:0]        exp_q,
  output logic              match_valid,
  output logic [2:0]        match_q,
  output logic              mismatch,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  fail_cnt,
  output logic [ADDR_W-1:0] first_fail_addr,
  output logic [7:0]        first_fail_data,
  output logic [2:0]        first_fail_q,
  output logic [7:0]        fail_bitmap
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Background word produced by the write-side decoder for a pattern code.
  // Codes 110/111 have no background; they never match a legal word.
  function automatic logic [7:0] decode_pat(input logic [2:0] q);
    logic [7:0] w;
    case (q)
      3'b000:  w = 8'b1010_1010;
      3'b001:  w = 8'b0101_0101;
      3'b010:  w = 8'b1111_0000;
      3'b011:  w = 8'b0000_1111;
      3'b100:  w = 8'b0000_0000;
      3'b101:  w = 8'b1111_1111;
      default: w = 8'b0000_0000;
    endcase
    return w;
  endfunction

  state_t            state_reg, state_next;
  logic              match_valid_reg;
  logic [2:0]        match_q_reg;
  logic              mismatch_reg;
  logic [CNT_W-1:0]  fail_cnt_reg;
  logic [ADDR_W-1:0] first_fail_addr_reg;
  logic [7:0]        first_fail_data_reg;
  logic [2:0]        first_fail_q_reg;

  logic [5:0] pat_hit;
  logic [2:0] enc_q;
  logic       exp_illegal;
  logic       beat_fail;
  logic       beat_acc;

  // One comparator per legal background; the patterns are distinct so at
  // most one bit of pat_hit is ever set.
  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_hit
      assign pat_hit[gi] = (rd_data == decode_pat(3'(gi)));
    end
  endgenerate

  // Encode the read word; anything that is not a background encodes to 111.
  always_comb begin
    enc_q = 3'b111;
    for (int i = 0; i < 6; i++) begin
      if (pat_hit[i]) enc_q = 3'(i);
    end
  end

  // An illegal expectation fails even when the data itself encodes to 111.
  assign exp_illegal = exp_q[2] & exp_q[1];
  assign beat_fail   = exp_illegal || (enc_q != exp_q);
  // A beat sharing its cycle with start belongs to no run and is dropped.
  assign beat_acc    = (state_reg == RUN) && rd_valid && !start;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic; start takes priority over end_run in every state.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (start) state_next = RUN;
               else if (end_run) state_next = DONE;
      DONE:    if (start) state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  // Per-beat result and run statistics. fail_cnt==0 marks "no failure yet"
  // because the counter saturates instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      match_valid_reg     <= 1'b0;
      match_q_reg         <= 3'b000;
      mismatch_reg        <= 1'b0;
      fail_cnt_reg        <= '0;
      first_fail_addr_reg <= '0;
      first_fail_data_reg <= 8'h00;
      first_fail_q_reg    <= 3'b000;
    end else if (start) begin
      match_valid_reg     <= 1'b0;
      mismatch_reg        <= 1'b0;
      fail_cnt_reg        <= '0;
      first_fail_addr_reg <= '0;
      first_fail_data_reg <= 8'h00;
      first_fail_q_reg    <= 3'b000;
    end else begin
      match_valid_reg <= beat_acc;
      if (beat_acc) begin
        match_q_reg  <= enc_q;
        mismatch_reg <= beat_fail;
        if (beat_fail) begin
          if (fail_cnt_reg != CNT_MAX) fail_cnt_reg <= fail_cnt_reg + CNT_W'(1);
          if (fail_cnt_reg == '0) begin
            first_fail_addr_reg <= rd_addr;
            first_fail_data_reg <= rd_data;
            first_fail_q_reg    <= exp_q;
          end
        end
      end
    end
  end

`ifdef MBIST_CHK_BITMAP_EN
  logic [7:0] fail_bitmap_reg;

  // Sticky map of data bits that differed from the expected background.
  always_ff @(posedge clk) begin
    if (rst || start)                  fail_bitmap_reg <= 8'h00;
    else if (beat_acc && !exp_illegal) fail_bitmap_reg <= fail_bitmap_reg | (rd_data ^ decode_pat(exp_q));
  end

  assign fail_bitmap = fail_bitmap_reg;
`else
  assign fail_bitmap = 8'h00;
`endif

  assign match_valid     = match_valid_reg;
  assign match_q         = match_q_reg;
  assign mismatch        = mismatch_reg;
  assign fail_cnt        = fail_cnt_reg;
  assign first_fail_addr = first_fail_addr_reg;
  assign first_fail_data = first_fail_data_reg;
  assign first_fail_q    = first_fail_q_reg;
  assign busy            = (state_reg == RUN);
  assign done            = (state_reg == DONE);
  assign pass            = (state_reg == DONE) && (fail_cnt_reg == '0);

endmodule

// File: tb/tb_bg_pattern_checker.sv
// Testbench for bg_pattern_checker: per-beat results go through a scoreboard
// queue, run statistics are checked inline by each scenario task.
module tb_bg_pattern_checker;

  logic       clk = 1'b0;
  logic       rst, start, end_run, rd_valid;
  logic [7:0] rd_data;
  logic [3:0] rd_addr;
  logic [2:0] exp_q;
  logic       match_valid, mismatch, busy, done, pass;
  logic [2:0] match_q, first_fail_q;
  logic [7:0] fail_cnt, first_fail_data, fail_bitmap;
  logic [3:0] first_fail_addr;

  int checks   = 0;
  int failures = 0;
  logic [3:0] sb[$];   // {expected match_q, expected mismatch}

  bg_pattern_checker #(.ADDR_W(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .end_run(end_run),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_addr(rd_addr), .exp_q(exp_q),
    .match_valid(match_valid), .match_q(match_q), .mismatch(mismatch),
    .busy(busy), .done(done), .pass(pass), .fail_cnt(fail_cnt),
    .first_fail_addr(first_fail_addr), .first_fail_data(first_fail_data),
    .first_fail_q(first_fail_q), .fail_bitmap(fail_bitmap)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] model_pat(input logic [2:0] q);
    case (q)
      3'd0: return 8'hAA;
      3'd1: return 8'h55;
      3'd2: return 8'hF0;
      3'd3: return 8'h0F;
      3'd4: return 8'h00;
      3'd5: return 8'hFF;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [2:0] model_enc(input logic [7:0] d);
    case (d)
      8'hAA: return 3'd0;
      8'h55: return 3'd1;
      8'hF0: return 3'd2;
      8'h0F: return 3'd3;
      8'h00: return 3'd4;
      8'hFF: return 3'd5;
      default: return 3'd7;
    endcase
  endfunction

  // Scoreboard pop: every match_valid pulse must correspond to a pushed beat.
  always @(negedge clk) begin
    if (match_valid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL beat_unexpected: match_valid=1 with no beat pending (match_q=%b)", match_q);
      end else begin
        logic [3:0] e;
        e = sb.pop_front();
        if ({match_q, mismatch} !== e) begin
          failures++;
          $display("FAIL beat_result: got match_q=%b mismatch=%b, want match_q=%b mismatch=%b",
                   match_q, mismatch, e[3:1], e[0]);
        end
      end
    end
  end

  // Drive one read beat; acc says whether the DUT should accept it.
  task automatic beat(input logic [2:0] q, input logic [7:0] d, input logic [3:0] a,
                      input bit acc, input bit er);
    @(negedge clk);
    start = 1'b0; end_run = er; rd_valid = 1'b1;
    rd_data = d; rd_addr = a; exp_q = q;
    if (acc) sb.push_back({model_enc(d), (q[2] & q[1]) || (model_enc(d) != q)});
    $display("beat q=%b data=%h addr=%0d acc=%0b end_run=%0b", q, d, a, acc, er);
  endtask

  task automatic drive_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start = 1'b0; end_run = 1'b0; rd_valid = 1'b0; rst = 1'b0;
    end
  endtask

  task automatic pulse_start(input bit with_beat);
    @(negedge clk);
    start = 1'b1; end_run = 1'b0; rd_valid = with_beat;
    rd_data = 8'h13; exp_q = 3'd0; rd_addr = 4'd9;
    $display("start with_beat=%0b", with_beat);
  endtask

  task automatic pulse_end();
    @(negedge clk);
    start = 1'b0; end_run = 1'b1; rd_valid = 1'b0;
    $display("end_run");
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; end_run = 1'b0; rd_valid = 1'b1;
    rd_data = 8'h5A; rd_addr = 4'd1; exp_q = 3'd0;
    repeat (3) @(negedge clk);
    checks++;
    if ({match_valid, match_q, mismatch, busy, done, pass, fail_cnt, first_fail_addr,
         first_fail_data, first_fail_q, fail_bitmap} !== 42'd0) begin
      failures++;
      $display("FAIL reset_outputs: busy=%b done=%b fail_cnt=%0d mv=%b mq=%b mm=%b, want all 0",
               busy, done, fail_cnt, match_valid, match_q, mismatch);
    end
    drive_idle(1);
    // Beats in IDLE are ignored.
    beat(3'd0, 8'h11, 4'd2, 1'b0, 1'b0);
    beat(3'd1, 8'h55, 4'd3, 1'b0, 1'b1);
    drive_idle(2);
    checks++;
    if ({busy, done, fail_cnt} !== 10'd0) begin
      failures++;
      $display("FAIL idle_ignore: busy=%b done=%b fail_cnt=%0d, want 0 0 0", busy, done, fail_cnt);
    end
  endtask

  task automatic test_all_patterns();
    pulse_start(1'b0);
    for (int i = 0; i < 6; i++) beat(3'(i), model_pat(3'(i)), 4'(i), 1'b1, 1'b0);
    @(negedge clk);
    rd_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL run_busy: busy=%b, want 1", busy);
    end
    pulse_end();
    drive_idle(1);
    checks++;
    if ({done, pass, busy, fail_cnt} !== {3'b110, 8'd0}) begin
      failures++;
      $display("FAIL all_patterns_done: done=%b pass=%b busy=%b fail_cnt=%0d, want 1 1 0 0",
               done, pass, busy, fail_cnt);
    end
  endtask

  task automatic test_mismatch();
    pulse_start(1'b0);
    beat(3'b010, 8'hF1, 4'd3, 1'b1, 1'b0);
    beat(3'b100, 8'h04, 4'd7, 1'b1, 1'b0);
    pulse_end();
    drive_idle(1);
    checks++;
    if ({fail_cnt, first_fail_addr, first_fail_data, first_fail_q, done, pass}
        !== {8'd2, 4'd3, 8'hF1, 3'b010, 2'b10}) begin
      failures++;
      $display("FAIL mismatch_stats: fail_cnt=%0d ffa=%0d ffd=%h ffq=%b done=%b pass=%b, want 2 3 f1 010 1 0",
               fail_cnt, first_fail_addr, first_fail_data, first_fail_q, done, pass);
    end
  endtask

  task automatic test_illegal_exp();
    pulse_start(1'b0);
    beat(3'b110, 8'hAA, 4'd4, 1'b1, 1'b0);
    beat(3'b111, 8'h66, 4'd5, 1'b1, 1'b0);
    pulse_end();
    drive_idle(1);
    checks++;
    if ({fail_cnt, first_fail_q, pass} !== {8'd2, 3'b110, 1'b0}) begin
      failures++;
      $display("FAIL illegal_exp: fail_cnt=%0d ffq=%b pass=%b, want 2 110 0", fail_cnt, first_fail_q, pass);
    end
  endtask

  task automatic test_saturate();
    pulse_start(1'b0);
    for (int i = 0; i < 300; i++) beat(3'd0, 8'h5A, 4'(i), 1'b1, 1'b0);
    drive_idle(2);
    checks++;
    if (fail_cnt !== 8'd255) begin
      failures++;
      $display("FAIL saturate: fail_cnt=%0d, want 255", fail_cnt);
    end
    beat(3'd1, 8'h00, 4'd1, 1'b1, 1'b0);
    drive_idle(2);
    checks++;
    if (fail_cnt !== 8'd255) begin
      failures++;
      $display("FAIL saturate_hold: fail_cnt=%0d, want 255", fail_cnt);
    end
    pulse_start(1'b1);      // the failing beat on the start cycle is dropped
    drive_idle(1);
    checks++;
    if ({fail_cnt, mismatch, match_valid, first_fail_data, busy} !== {8'd0, 2'b00, 8'h00, 1'b1}) begin
      failures++;
      $display("FAIL start_clear: fail_cnt=%0d mm=%b mv=%b ffd=%h busy=%b, want 0 0 0 00 1",
               fail_cnt, mismatch, match_valid, first_fail_data, busy);
    end
  endtask

  task automatic test_end_with_beat();
    beat(3'd3, 8'h0E, 4'd6, 1'b1, 1'b1);
    drive_idle(1);
    checks++;
    if ({done, fail_cnt, pass, first_fail_addr} !== {1'b1, 8'd1, 1'b0, 4'd6}) begin
      failures++;
      $display("FAIL end_with_beat: done=%b fail_cnt=%0d pass=%b ffa=%0d, want 1 1 0 6",
               done, fail_cnt, pass, first_fail_addr);
    end
    beat(3'd2, 8'h77, 4'd8, 1'b0, 1'b0);   // ignored in DONE
    drive_idle(1);
    checks++;
    if ({done, fail_cnt} !== {1'b1, 8'd1}) begin
      failures++;
      $display("FAIL done_ignore: done=%b fail_cnt=%0d, want 1 1", done, fail_cnt);
    end
    @(negedge clk);
    start = 1'b1; end_run = 1'b1; rd_valid = 1'b0;
    $display("start with end_run");
    drive_idle(1);
    checks++;
    if ({busy, done, fail_cnt} !== {2'b10, 8'd0}) begin
      failures++;
      $display("FAIL start_wins: busy=%b done=%b fail_cnt=%0d, want 1 0 0", busy, done, fail_cnt);
    end
  endtask

  task automatic test_rst_midrun();
    beat(3'd0, 8'h01, 4'd2, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b1; rd_valid = 1'b1; rd_data = 8'h02; exp_q = 3'd0;
    $display("rst mid-run");
    @(negedge clk);
    checks++;
    if ({match_valid, match_q, mismatch, busy, done, pass, fail_cnt, first_fail_addr,
         first_fail_data, first_fail_q, fail_bitmap} !== 42'd0) begin
      failures++;
      $display("FAIL rst_midrun: busy=%b fail_cnt=%0d mv=%b mm=%b ffd=%h, want all 0",
               busy, fail_cnt, match_valid, mismatch, first_fail_data);
    end
    drive_idle(1);
  endtask

  task automatic test_bitmap();
    logic [7:0] want;
`ifdef MBIST_CHK_BITMAP_EN
    want = 8'b1000_0001;
`else
    want = 8'b0000_0000;
`endif
    pulse_start(1'b0);
    beat(3'b000, 8'hAB, 4'd1, 1'b1, 1'b0);
    beat(3'b101, 8'h7F, 4'd2, 1'b1, 1'b0);
    beat(3'b110, 8'h3C, 4'd3, 1'b1, 1'b0);   // illegal: no bitmap update
    pulse_end();
    drive_idle(1);
    checks++;
    if ({fail_bitmap, fail_cnt} !== {want, 8'd3}) begin
      failures++;
      $display("FAIL bitmap: fail_bitmap=%b fail_cnt=%0d, want %b 3", fail_bitmap, fail_cnt, want);
    end
  endtask

  task automatic check_drained(input string name);
    drive_idle(2);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s_drain: %0d beats never produced match_valid, want 0", name, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    test_reset();        check_drained("reset");
    test_all_patterns(); check_drained("all_patterns");
    test_mismatch();     check_drained("mismatch");
    test_illegal_exp();  check_drained("illegal_exp");
    test_saturate();     check_drained("saturate");
    test_end_with_beat(); check_drained("end_with_beat");
    test_rst_midrun();   check_drained("rst_midrun");
    test_bitmap();       check_drained("bitmap");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bg_pattern_checker.md
Name: bg_pattern_checker

Overview:
- Read-side counterpart of the MBIST background decoder. The decoder maps a 3-bit pattern select q to an 8-bit background word; this block does the reverse on memory read data.
- It encodes each read word back to its pattern code and compares that code with the expected code from the MBIST controller.
- It accumulates pass/fail statistics for one test run and captures the first failing read.
- It sits between the memory read port and the MBIST controller's result logic.

Parameters:
- ADDR_W, 4, width of the read address captured on first failure.
- CNT_W, 8, width of the saturating mismatch counter.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; clears statistics and begins a run.
- end_run  in  1  one-cycle pulse; ends the current run.
- rd_valid  in  1  a read beat is present this cycle.
- rd_data  in  8  memory read data.
- rd_addr  in  ADDR_W  address of the read beat.
- exp_q  in  3  expected pattern code for this beat.
- match_valid  out  1  registered per-beat result is valid.
- match_q  out  3  encoded pattern of the last beat.
- mismatch  out  1  the last beat failed.
- busy  out  1  the block is in RUN.
- done  out  1  the block is in DONE; result is stable.
- pass  out  1  valid while done; 1 when fail_cnt==0.
- fail_cnt  out  CNT_W  saturating count of failed beats.
- first_fail_addr  out  ADDR_W  rd_addr of the first failing beat.
- first_fail_data  out  8  rd_data of the first failing beat.
- first_fail_q  out  3  exp_q of the first failing beat.
- fail_bitmap  out  8  per-bit fail map (see Optional Feature).

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset values: state=IDLE; every output is 0.
- Encoding (combinational, internal):
  - 10101010 -> 000
  - 01010101 -> 001
  - 11110000 -> 010
  - 00001111 -> 011
  - 00000000 -> 100
  - 11111111 -> 101
  - any other word -> 111 (no match).
- Beat fails when either holds:
  - encoded code != exp_q;
  - exp_q is 110 or 111 (illegal expectation). This always fails, even if the data encodes to 111.
- States:
  - IDLE: rd_valid and end_run are ignored; start -> RUN.
  - RUN: each rd_valid beat is checked; end_run -> DONE; start -> RUN with statistics cleared.
  - DONE: done=1, pass=(fail_cnt==0); rd_valid and end_run are ignored; start -> RUN.
- Latency: a beat accepted at edge N updates match_valid/match_q/mismatch/fail_cnt visible after edge N, one cycle.
  - match_valid is a single-cycle pulse per beat; it is 0 when no beat was accepted.
  - match_q and mismatch hold their last values between beats.
- fail_cnt increments by 1 per failed beat and saturates at 2^CNT_W-1; it never wraps.
- first_fail_*: loaded only on the first failed beat after start, then frozen until the next start.
- start clears fail_cnt, first_fail_*, fail_bitmap, match_valid and mismatch in the same edge. A rd_valid in the same cycle as start is dropped.
- end_run together with rd_valid in RUN: the beat is checked and counted. done/pass in the next cycle include that beat.
- start together with end_run: start wins.
- rst mid-run: immediate return to IDLE with all outputs 0 on the next edge.

Optional Feature:
- Macro: MBIST_CHK_BITMAP_EN.
- Defined: in RUN, each accepted beat with legal exp_q ORs (rd_data XOR decoded pattern of exp_q) into fail_bitmap.
  - This gives the sticky set of failing data bits.
  - Beats with illegal exp_q do not update the bitmap.
  - start clears it.
- Undefined: fail_bitmap is tied to 0; no bitmap registers are synthesized.

Test Plan:
- Reset, start, then 6 beats, each with rd_data equal to the pattern for exp_q=000..101 -> match_q follows exp_q one cycle later, mismatch=0. After end_run: done=1, pass=1, fail_cnt=0.
- Run with beats (exp_q=010, data 11110001) then (exp_q=100, data 00000100) -> match_q=111 both times, fail_cnt=2, first_fail_addr/data/q = first beat's values, pass=0.
- exp_q=110 with data 10101010, then exp_q=111 with data 01100110 -> both counted as fails, fail_cnt=2.
- CNT_W=8, 300 failing beats -> fail_cnt=255 and it stays there. start then clears it to 0; rd_valid on the start cycle is not counted.
- end_run together with a failing rd_valid -> next cycle done=1, fail_cnt=1, pass=0. rst asserted mid-run -> all outputs 0, busy=0.
- With MBIST_CHK_BITMAP_EN defined: beats exp_q=000 with data 10101011, then exp_q=101 with data 01111111 -> fail_bitmap=10000001. Without the macro -> fail_bitmap=00000000.
